// File: rtl/spi_boot_master.sv
// spi_boot_master: SPI mode-0 master issuing 0x02 write / 0x0B read burst transactions
module spi_boot_master #(
    parameter int CLK_DIV = 2,
    parameter int DUMMY_CYCLES = 32,
    parameter int CSN_GAP = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic        rw_i,
    input  logic [31:0] addr_i,
    input  logic [7:0]  len_i,
    input  logic [31:0] wdata_i,
    input  logic        wvalid_i,
    output logic        wready_o,
    output logic [31:0] rdata_o,
    output logic        rvalid_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        spi_sck_o,
    output logic        spi_csn_o,
    output logic        spi_sdo_o,
    input  logic        spi_sdi_i
);
    localparam int CMAX = (2 * CLK_DIV > CSN_GAP) ? 2 * CLK_DIV : CSN_GAP;
    localparam int CW = $clog2(CMAX + 1);
    localparam logic [CW-1:0] DIV_M1 = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] HOLD_M1 = CW'(2 * CLK_DIV - 1);
    localparam logic [CW-1:0] GAP_M1 = CW'(CSN_GAP - 1);
    localparam logic [5:0] DUMMY_LAST = 6'(DUMMY_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, SETUP, CMD, ADDR, DUMMY, DATA, HOLD, GAP} state_t;

    state_t      state;
    logic [CW-1:0] cnt;
    logic [5:0]  bits;
    logic [8:0]  words;
    logic [31:0] sr;
    logic [31:0] rx;
    logic [31:0] addr;
    logic [7:0]  len;
    logic        rw;
    logic        rdy;
    logic [5:0]  last_bit;
    logic        last_word;

    // the presented MOSI bit is always the top of the transmit shift register
    assign spi_sdo_o = sr[31];

    // index of the final bit in the current shifting state, and final-word flag
    always_comb begin
        last_bit = state == CMD ? 6'd7 : state == DUMMY ? DUMMY_LAST : 6'd31;
        last_word = words == {1'b0, len};
    end

    // sequencer: SCK generation, shifting, write handshake, read delivery and framing
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            bits <= '0;
            words <= '0;
            sr <= '0;
            rx <= '0;
            addr <= '0;
            len <= '0;
            rw <= 1'b0;
            rdy <= 1'b0;
            spi_csn_o <= 1'b1;
            spi_sck_o <= 1'b0;
            wready_o <= 1'b0;
            rvalid_o <= 1'b0;
            done_o <= 1'b0;
            busy_o <= 1'b0;
            rdata_o <= '0;
        end else begin
            done_o <= 1'b0;
            rvalid_o <= rdy;
            rdy <= 1'b0;
            if (rdy) rdata_o <= rx;
            case (state)
                IDLE: if (start_i) begin
                    state <= SETUP;
                    rw <= rw_i;
                    addr <= addr_i;
                    len <= len_i;
                    sr <= {rw_i ? 8'h0B : 8'h02, 24'd0};
                    cnt <= DIV_M1;
                    bits <= '0;
                    words <= '0;
                    spi_csn_o <= 1'b0;
                    busy_o <= 1'b1;
                end
                SETUP: if (cnt != '0) cnt <= cnt - 1'b1;
                else begin
                    state <= CMD;
                    spi_sck_o <= 1'b1;
                    cnt <= DIV_M1;
                end
                HOLD: if (cnt != '0) cnt <= cnt - 1'b1;
                else begin
                    state <= GAP;
                    spi_csn_o <= 1'b1;
                    done_o <= 1'b1;
                    cnt <= GAP_M1;
                end
                GAP: if (cnt != '0) cnt <= cnt - 1'b1;
                else begin
                    state <= IDLE;
                    busy_o <= 1'b0;
                end
                default: if (wready_o) begin
                    if (wvalid_i) begin
                        sr <= wdata_i;
                        wready_o <= 1'b0;
                        cnt <= cnt == '0 ? DIV_M1 : cnt - 1'b1;
                    end else if (cnt != '0) cnt <= cnt - 1'b1;
                end else if (cnt != '0) cnt <= cnt - 1'b1;
                else if (!spi_sck_o) begin
                    spi_sck_o <= 1'b1;
                    cnt <= DIV_M1;
                    if (state == DATA && rw) begin
                        rx <= {rx[30:0], spi_sdi_i};
                        rdy <= bits == 6'd31;
                    end
                end else begin
                    spi_sck_o <= 1'b0;
                    cnt <= DIV_M1;
                    if (bits != last_bit) begin
                        bits <= bits + 6'd1;
                        sr <= sr << 1;
                    end else begin
                        bits <= '0;
                        sr <= '0;
                        if (state == CMD) begin
                            state <= ADDR;
                            sr <= addr;
                        end else if (state == ADDR) begin
                            state <= (rw && DUMMY_CYCLES > 0) ? DUMMY : DATA;
                            wready_o <= !rw;
                        end else if (state == DUMMY) state <= DATA;
                        else if (last_word) begin
                            state <= HOLD;
                            cnt <= HOLD_M1;
                        end else begin
                            words <= words + 9'd1;
                            wready_o <= !rw;
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_spi_boot_master.sv
// tb_spi_boot_master: directed vector bench with an SPI slave model for spi_boot_master
module tb_spi_boot_master;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_i = 1'b0;
    logic        rw_i = 1'b0;
    logic [31:0] addr_i = '0;
    logic [7:0]  len_i = '0;
    logic [31:0] wdata_i = '0;
    logic        wvalid_i = 1'b0;
    logic        wready_o;
    logic [31:0] rdata_o;
    logic        rvalid_o;
    logic        busy_o;
    logic        done_o;
    logic        spi_sck_o;
    logic        spi_csn_o;
    logic        spi_sdo_o;
    logic        miso = 1'b0;

    spi_boot_master dut (
        .clk(clk), .rst(rst), .start_i(start_i), .rw_i(rw_i), .addr_i(addr_i), .len_i(len_i),
        .wdata_i(wdata_i), .wvalid_i(wvalid_i), .wready_o(wready_o), .rdata_o(rdata_o),
        .rvalid_o(rvalid_o), .busy_o(busy_o), .done_o(done_o), .spi_sck_o(spi_sck_o),
        .spi_csn_o(spi_csn_o), .spi_sdo_o(spi_sdo_o), .spi_sdi_i(miso)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rw;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [31:0] w0;
        logic [31:0] r0;
        int          stall_len;
        int          exp_rises;
        int          exp_hs;
    } vec_t;

    vec_t vecs [6];
    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] w0 = '0;
    logic [31:0] r0 = '0;
    int stall_len = 0;
    logic wv_en = 1'b0;
    int hs_base = 0;
    int stalled = 0;

    int hs_total = 0;
    int rv_total = 0;
    logic [31:0] rv_data [16];
    int done_total = 0;
    int done_bad = 0;
    int stall_viol = 0;
    int wr_run = 0;
    int max_wr_run = 0;
    int hi_run = 0;
    int last_gap = 0;
    logic prev_csn = 1'b1;

    int nb = 0;
    logic [31:0] sh = '0;
    logic [7:0] cmd_got = '0;
    logic [31:0] addr_got = '0;
    int mosi_ones = 0;
    int bad_sck = 0;
    logic [31:0] got [256];

    function automatic logic [31:0] wgen(input logic [31:0] b, input int k);
        return b ^ (32'(k) * 32'h1111_1111);
    endfunction

    function automatic logic [31:0] rgen(input logic [31:0] b, input int k);
        return b + 32'(k) * 32'h8888_8878;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // slave: samples MOSI on SCK rise, restarts framing on CSN fall
    always @(posedge spi_sck_o or negedge spi_csn_o) begin
        if (!spi_sck_o) begin
            nb = 0;
            mosi_ones = 0;
        end else if (spi_csn_o) bad_sck++;
        else begin
            sh = {sh[30:0], spi_sdo_o};
            nb++;
            if (nb == 8) cmd_got = sh[7:0];
            if (nb == 40) addr_got = sh;
            if (nb > 40 && cmd_got == 8'h0B && spi_sdo_o) mosi_ones++;
            if (nb > 40 && cmd_got == 8'h02 && (nb - 40) % 32 == 0) got[((nb - 40) / 32 - 1) & 255] = sh;
        end
    end

    // slave read data: drives MISO on SCK fall once the dummy cycles are over
    always @(negedge spi_sck_o) begin
        int k;
        logic [31:0] wd;
        if (nb >= 72 && cmd_got == 8'h0B) begin
            k = nb - 72;
            wd = rgen(r0, k / 32);
            miso = wd[31 - (k % 32)];
        end
    end

    // write source: withholds wvalid for stall_len ready cycles before word 2
    always @(posedge clk) begin
        #1;
        if (!wv_en) begin
            stalled = 0;
            wvalid_i = 1'b0;
        end else if (stall_len > 0 && hs_total - hs_base == 2 && stalled < stall_len) begin
            wvalid_i = 1'b0;
            if (wready_o) stalled++;
        end else wvalid_i = 1'b1;
        wdata_i = wgen(w0, hs_total - hs_base);
    end

    // monitor sampled mid-cycle
    always @(negedge clk) begin
        if (wready_o && wvalid_i) hs_total++;
        if (rvalid_o) begin
            rv_data[rv_total & 15] = rdata_o;
            rv_total++;
        end
        if (done_o) begin
            done_total++;
            if (!(spi_csn_o && !prev_csn)) done_bad++;
        end
        if (wready_o && !wvalid_i && (spi_sck_o || spi_csn_o)) stall_viol++;
        wr_run = wready_o ? wr_run + 1 : 0;
        if (wr_run > max_wr_run) max_wr_run = wr_run;
        if (spi_csn_o) hi_run++;
        else begin
            if (hi_run > 0) last_gap = hi_run;
            hi_run = 0;
        end
        prev_csn = spi_csn_o;
    end

    task automatic run_vec(input vec_t v, input string nm);
        int t;
        int d0;
        int rc;
        d0 = done_total;
        rc = rv_total;
        hs_base = hs_total;
        w0 = v.w0;
        r0 = v.r0;
        stall_len = v.stall_len;
        wv_en = !v.rw;
        @(posedge clk); #1;
        rw_i = v.rw;
        addr_i = v.addr;
        len_i = v.len;
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        t = 0;
        while (done_total == d0 && t < 40000) begin
            @(negedge clk);
            t++;
        end
        repeat (12) @(negedge clk);
        check({nm, " done count"}, 32'(done_total - d0), 32'd1);
        check({nm, " idle"}, {30'd0, busy_o, spi_csn_o}, 32'd1);
        check({nm, " sck rises"}, 32'(nb), 32'(v.exp_rises));
        check({nm, " cmd"}, {24'd0, cmd_got}, v.rw ? 32'h0B : 32'h02);
        check({nm, " addr"}, addr_got, v.addr);
        check({nm, " handshakes"}, 32'(hs_total - hs_base), 32'(v.exp_hs));
        check({nm, " done with csn rise"}, 32'(done_bad), 32'd0);
        check({nm, " sck while csn high"}, 32'(bad_sck), 32'd0);
        if (v.rw) begin
            check({nm, " rvalid count"}, 32'(rv_total - rc), 32'(int'(v.len) + 1));
            check({nm, " mosi zero"}, 32'(mosi_ones), 32'd0);
            for (int k = 0; k <= int'(v.len); k++)
                check($sformatf("%s rdata%0d", nm, k), rv_data[(rc + k) & 15], rgen(v.r0, k));
        end else begin
            for (int k = 0; k <= int'(v.len); k++)
                check($sformatf("%s wword%0d", nm, k), got[k], wgen(v.w0, k));
        end
        if (v.stall_len > 0) begin
            check({nm, " stall sck/csn low"}, 32'(stall_viol), 32'd0);
            check({nm, " stall length"}, 32'(max_wr_run >= v.stall_len), 32'd1);
        end
        wv_en = 1'b0;
    endtask

    initial begin
        int t;
        int d0;
        vecs[0] = '{1'b0, 32'h0000_0000, 8'd0,   32'hDEAD_BEEF, 32'h0,          0,  72,   1};
        vecs[1] = '{1'b0, 32'h0010_0000, 8'd3,   32'hCAFE_0001, 32'h0,          50, 168,  4};
        vecs[2] = '{1'b1, 32'h1A10_7008, 8'd1,   32'h0,         32'h1234_5678,  0,  136,  0};
        vecs[3] = '{1'b0, 32'hA5A5_0F0F, 8'd1,   32'h0000_FFFF, 32'h0,          0,  104,  2};
        vecs[4] = '{1'b1, 32'hFFFF_FFFC, 8'd0,   32'h0,         32'h8000_0001,  0,  104,  0};
        vecs[5] = '{1'b0, 32'h0000_0000, 8'd255, 32'h1357_9BDF, 32'h0,          0,  8232, 256};

        repeat (3) @(posedge clk);
        #1;
        check("reset csn", 32'(spi_csn_o), 32'd1);
        check("reset sck", 32'(spi_sck_o), 32'd0);
        check("reset sdo", 32'(spi_sdo_o), 32'd0);
        check("reset wready", 32'(wready_o), 32'd0);
        check("reset rvalid", 32'(rvalid_o), 32'd0);
        check("reset done", 32'(done_o), 32'd0);
        check("reset busy", 32'(busy_o), 32'd0);
        check("reset rdata", rdata_o, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("v%0d", i));

        check("read word0 literal", rv_data[0], 32'h1234_5678);
        check("read word1 literal", rv_data[1], 32'h9ABC_DEF0);

        d0 = done_total;
        hs_base = hs_total;
        w0 = 32'h0F0F_0F0F;
        stall_len = 0;
        wv_en = 1'b1;
        @(posedge clk); #1;
        rw_i = 1'b0;
        addr_i = 32'h5555_AAAA;
        len_i = 8'd2;
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        t = 0;
        while (nb < 18 && t < 1000) begin
            @(negedge clk);
            t++;
        end
        check("midrst reached addr bit 10", 32'(nb >= 18), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst csn", 32'(spi_csn_o), 32'd1);
        check("midrst sck", 32'(spi_sck_o), 32'd0);
        check("midrst busy", 32'(busy_o), 32'd0);
        check("midrst rdata", rdata_o, 32'd0);
        wv_en = 1'b0;
        repeat (20) @(negedge clk);
        check("midrst no done", 32'(done_total - d0), 32'd0);
        run_vec(vecs[0], "after reset");

        d0 = done_total;
        hs_base = hs_total;
        w0 = 32'h0BAD_F00D;
        wv_en = 1'b1;
        @(posedge clk); #1;
        rw_i = 1'b0;
        addr_i = 32'h0000_0100;
        len_i = 8'd0;
        start_i = 1'b1;
        t = 0;
        while (done_total < d0 + 2 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        @(posedge clk); #1;
        start_i = 1'b0;
        repeat (30) @(negedge clk);
        check("b2b done count", 32'(done_total - d0), 32'd2);
        check("b2b csn gap", 32'(last_gap >= 4), 32'd1);
        check("b2b second rises", 32'(nb), 32'd72);
        check("b2b sck while csn high", 32'(bad_sck), 32'd0);
        check("b2b handshakes", 32'(hs_total - hs_base), 32'd2);
        wv_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/spi_boot_master.md
Name: spi_boot_master

Overview:
- Synthesizable SPI master, single-lane, mode 0, MSB first.
- Issues the memory-load protocol of the on-chip SPI slave: write command 0x02 and read command 0x0B, each followed by a 32-bit address and a burst of 32-bit words.
- Intended as the active end of the boot/load interface, so an external controller FPGA or companion chip can load and check L2 without the testbench SPI tasks.
- Word-level valid/ready streaming on the system side.

Parameters:
- CLK_DIV, 2, SCK half-period in clk cycles; legal range ≥1.
- DUMMY_CYCLES, 32, SCK cycles between the last address bit and the first read data bit. Must match the slave's dummy register.
- CSN_GAP, 4, minimum clk cycles that CSN stays high between transactions.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- start_i  in  1  transaction request; sampled only while busy_o=0
- rw_i  in  1  0=write (cmd 0x02), 1=read (cmd 0x0B); captured with start_i
- addr_i  in  32  start address; captured with start_i
- len_i  in  8  word count minus one (0→1 word, 255→256 words); captured with start_i
- wdata_i  in  32  write word
- wvalid_i  in  1  write word valid
- wready_o  out  1  write word accepted when wvalid_i && wready_o
- rdata_o  out  32  read word
- rvalid_o  out  1  one-cycle pulse when rdata_o is valid; no backpressure
- busy_o  out  1  high from the cycle after start is accepted until done_o
- done_o  out  1  one-cycle pulse at the end of the transaction
- spi_sck_o  out  1  SPI clock, idle low
- spi_csn_o  out  1  chip select, active-low
- spi_sdo_o  out  1  master out
- spi_sdi_i  in  1  master in

Behaviour:
- Reset: on any clk edge with rst=1, every output returns to its reset value: spi_csn_o=1, spi_sck_o=0, spi_sdo_o=0, wready_o=0, rvalid_o=0, done_o=0, busy_o=0, rdata_o=0, state=IDLE.
  - This applies mid-transaction too: the transfer is abandoned with no done_o.
- States: IDLE → SETUP → CMD (8 bits) → ADDR (32 bits) → [read: DUMMY] → DATA (32×(len_i+1) bits) → HOLD → GAP → IDLE.
- IDLE to SETUP: start_i=1 in IDLE latches rw_i, addr_i and len_i. The next edge enters SETUP with busy_o=1 and spi_csn_o=0. Start requests while busy are ignored.
- SETUP: lasts CLK_DIV cycles. spi_sdo_o presents bit 7 of the command.
- Bit timing:
  - Each bit is one SCK period: CLK_DIV cycles high, then CLK_DIV cycles low.
  - The slave samples on the rising edge.
  - spi_sdo_o updates on the same clk edge that drives SCK low.
  - spi_sdi_i is sampled on the clk edge that drives SCK high.
- DUMMY: spi_sdo_o=0 for DUMMY_CYCLES SCK periods.
- Write data flow:
  - A word must be held in the shift register before its first bit is presented.
  - wready_o=1 in the cycle the next word is required: during the last ADDR bit's low phase, or the last bit's low phase of the previous word.
  - The handshake completes when wvalid_i=1 in that cycle. wready_o stays high until it does.
  - Underrun: while waiting, SCK holds low and CSN holds low, with no timeout. SCK resumes CLK_DIV cycles after the accepting edge.
  - wready_o is never asserted for read transactions.
- Read data flow:
  - Bits shift in MSB first.
  - rdata_o updates and rvalid_o pulses on the clk edge after the 32nd rising-edge sample of each word.
  - Words are delivered in ascending address order.
- HOLD: after the final bit's low phase, SCK stays low and CSN stays low for CLK_DIV cycles. Then spi_csn_o=1 and done_o pulses in the same cycle.
- GAP: CSN stays high for CSN_GAP cycles. busy_o drops when IDLE is re-entered. A start_i arriving in GAP is ignored.
- SCK never toggles while CSN is high.
- Counters: the bit counter is 6 bits and the word counter is 9 bits. A 256-word burst (len_i=255) must terminate correctly with no wrap-around.
- SCK cycle count for a transaction (excluding underrun stalls):
  - write: 40 + 32×(len_i+1)
  - read: 40 + DUMMY_CYCLES + 32×(len_i+1)

Test Plan:
- Write, single word: CLK_DIV=2, addr_i=0x0000_0000, len_i=0, wdata_i=0xDEAD_BEEF always valid → 72 SCK rising edges. MOSI bits are 0x02, 0x00000000, 0xDEADBEEF. Exactly one wready handshake. done_o pulses once, with CSN rising in the same cycle.
- Write burst with underrun: addr_i=0x0010_0000, len_i=3, wvalid_i withheld for 50 cycles before word 2 → SCK stays low and CSN stays low during the stall. Slave model receives 4 words in order. Total rising edges = 168.
- Read: DUMMY_CYCLES=32, addr_i=0x1A10_7008, len_i=1, slave returns 0x1234_5678 then 0x9ABC_DEF0 → two rvalid_o pulses with those values. 136 SCK edges. MOSI is 0 during dummy and data bits.
- Reset mid-transfer: assert rst during the ADDR phase (bit 10) → next edge gives spi_csn_o=1, spi_sck_o=0, busy_o=0, and no done_o. A new start then completes normally.
- Back-to-back starts: start_i held high continuously, CSN_GAP=4 → CSN is high for ≥4 cycles between transactions. The second transaction begins only from IDLE, with no SCK edges while CSN is high.
- Max burst: len_i=255, write → exactly 256 handshakes, 8232 SCK edges, single done_o.
